// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages/EX unit and pipe_stall_ctrl.
// The controller side uses the slave modport; dbg_state/dbg_cnt expose the multi-cycle FSM.
interface pipe_stall_ctrl_if #(
    parameter int STALL_W  = 6,
    parameter int MC_LEN_W = 4,
    parameter int PERF_W   = 32
);
    logic                if_stall_req;
    logic                id_stall_req;
    logic                ex_mc_start;
    logic [MC_LEN_W-1:0] ex_mc_len;
    logic                ex_branch_flush;
    logic                mem_req;
    logic                mem_ack;
    logic [STALL_W-1:0]  ctrl_stall;
    logic                ctrl_flush;
    logic                ctrl_mc_done;
    logic [PERF_W-1:0]   perf_stall_cnt;
    logic [PERF_W-1:0]   perf_flush_cnt;
    logic [1:0]          dbg_state;
    logic [MC_LEN_W-1:0] dbg_cnt;

    modport master (
        output if_stall_req, id_stall_req, ex_mc_start, ex_mc_len,
               ex_branch_flush, mem_req, mem_ack,
        input  ctrl_stall, ctrl_flush, ctrl_mc_done,
               perf_stall_cnt, perf_flush_cnt, dbg_state, dbg_cnt
    );

    modport slave (
        input  if_stall_req, id_stall_req, ex_mc_start, ex_mc_len,
               ex_branch_flush, mem_req, mem_ack,
        output ctrl_stall, ctrl_flush, ctrl_mc_done,
               perf_stall_cnt, perf_flush_cnt, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall/flush sequencer: multi-cycle EX counter, MEM wait, deferred flush.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
    parameter int STALL_W  = 6,
    parameter int MC_LEN_W = 4,
    parameter int PERF_W   = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    mc_state_e           state;
    logic [MC_LEN_W-1:0] cnt;
    logic                flush_pend;

    logic                mem_wait;
    logic                mc_start_ok;
    logic                mc_stall;
    logic                mc_done_c;
    logic                flush_c;
    logic [STALL_W-1:0]  stall_c;

    assign mem_wait    = bus.mem_req & ~bus.mem_ack;
    assign mc_start_ok = (state == IDLE) && bus.ex_mc_start;
    assign mc_stall    = (state == BUSY) || (mc_start_ok && (bus.ex_mc_len != '0));
    assign mc_done_c   = (state == DONE) || (mc_start_ok && (bus.ex_mc_len == '0));
    assign flush_c     = (bus.ex_branch_flush | flush_pend) & ~mem_wait & ~mc_stall;

    always_comb begin
        stall_c = '0;
        if (mem_wait)
            stall_c[4:0] = 5'b11111;
        else if (mc_stall)
            stall_c[3:0] = 4'b1111;
        else if (bus.id_stall_req)
            stall_c[2:0] = 3'b111;
        else if (bus.if_stall_req)
            stall_c[1:0] = 2'b11;
        // A squash wins over load-use and fetch holds in the front stages.
        if (flush_c)
            stall_c[2:0] = 3'b000;
    end

    assign bus.ctrl_stall   = rst ? stall_c : '0;
    assign bus.ctrl_flush   = rst & flush_c;
    assign bus.ctrl_mc_done = rst & mc_done_c;
    assign bus.dbg_state    = state;
    assign bus.dbg_cnt      = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            // A branch that cannot flush now is blocked by mem_wait or mc_stall.
            if (flush_c)
                flush_pend <= 1'b0;
            else if (bus.ex_branch_flush)
                flush_pend <= 1'b1;

            // The whole FSM freezes while MEM waits on data memory.
            if (!mem_wait) begin
                case (state)
                    IDLE: begin
                        if (bus.ex_mc_start && (bus.ex_mc_len != '0)) begin
                            if (bus.ex_mc_len == MC_LEN_W'(1)) begin
                                state <= DONE;
                            end else begin
                                state <= BUSY;
                                cnt   <= bus.ex_mc_len - MC_LEN_W'(1);
                            end
                        end
                    end
                    BUSY: begin
                        if (cnt == MC_LEN_W'(1)) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - MC_LEN_W'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_c != '0)
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (flush_c)
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
`else
    assign bus.perf_stall_cnt = {PERF_W{1'b0}};
    assign bus.perf_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: each step drives inputs, checks outputs mid-cycle, then clocks.
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  pipe_stall_ctrl_if #(.STALL_W(6), .MC_LEN_W(4), .PERF_W(32)) bus ();

  pipe_stall_ctrl #(.STALL_W(6), .MC_LEN_W(4), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected perf value: counters exist only with the feature enabled
  function automatic logic [31:0] exp_perf(input int v);
`ifdef PIPE_PERF_CNT_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ifs, input logic ids, input logic st, input logic [3:0] len,
                       input logic br, input logic mreq, input logic mack);
    bus.if_stall_req    = ifs;
    bus.id_stall_req    = ids;
    bus.ex_mc_start     = st;
    bus.ex_mc_len       = len;
    bus.ex_branch_flush = br;
    bus.mem_req         = mreq;
    bus.mem_ack         = mack;
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    drive(0, 0, 0, 4'd0, 0, 0, 0);

    // reset state, with requests active to prove the outputs are forced low
    drive(1, 1, 1, 4'd3, 1, 1, 0);
    chk("rst_stall", 32'(bus.ctrl_stall), 32'h00);
    chk("rst_flush", 32'(bus.ctrl_flush), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'd0);
    chk("rst_perf_s", bus.perf_stall_cnt, 32'd0);
    drive(0, 0, 1, 4'd0, 0, 0, 0);
    chk("rst_done", 32'(bus.ctrl_mc_done), 32'd0);
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();

    chk("idle_stall", 32'(bus.ctrl_stall), 32'h00);

    // load-use for one cycle
    drive(0, 1, 0, 4'd0, 0, 0, 0);
    chk("lu_stall", 32'(bus.ctrl_stall), 32'h07);
    tick();
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    chk("lu_after", 32'(bus.ctrl_stall), 32'h00);
    chk("lu_perf", bus.perf_stall_cnt, exp_perf(1));

    // fetch stall, then fetch + load-use
    drive(1, 0, 0, 4'd0, 0, 0, 0);
    chk("if_stall", 32'(bus.ctrl_stall), 32'h03);
    tick();
    drive(1, 1, 0, 4'd0, 0, 0, 0);
    chk("if_id_stall", 32'(bus.ctrl_stall), 32'h07);
    tick();

    // multi-cycle len=4
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 4'd4, 0, 0, 0);
      chk($sformatf("mc4_stall%0d", k), 32'(bus.ctrl_stall), 32'h0F);
      chk($sformatf("mc4_done%0d", k), 32'(bus.ctrl_mc_done), 32'd0);
      tick();
    end
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    chk("mc4_done", 32'(bus.ctrl_mc_done), 32'd1);
    chk("mc4_stall_done", 32'(bus.ctrl_stall), 32'h00);
    chk("mc4_state_done", 32'(bus.dbg_state), 32'd2);
    tick();
    chk("mc4_idle", 32'(bus.dbg_state), 32'd0);
    chk("mc4_done_off", 32'(bus.ctrl_mc_done), 32'd0);
    chk("mc4_perf", bus.perf_stall_cnt, exp_perf(7));

    // mem wait over multi-cycle len=5: three stall cycles bring cnt to 2
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 4'd5, 0, 0, 0);
      chk($sformatf("mc5_stall%0d", k), 32'(bus.ctrl_stall), 32'h0F);
      tick();
    end
    chk("mc5_cnt2", 32'(bus.dbg_cnt), 32'd2);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 4'd5, 0, 1, 0);
      chk($sformatf("mw_stall%0d", k), 32'(bus.ctrl_stall), 32'h1F);
      tick();
      chk($sformatf("mw_cnt%0d", k), 32'(bus.dbg_cnt), 32'd2);
    end
    drive(0, 0, 1, 4'd5, 0, 1, 1);
    chk("mw_ack_stall", 32'(bus.ctrl_stall), 32'h0F);
    tick();
    drive(0, 0, 1, 4'd5, 0, 0, 0);
    chk("mw_last_stall", 32'(bus.ctrl_stall), 32'h0F);
    tick();
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    chk("mw_done", 32'(bus.ctrl_mc_done), 32'd1);
    chk("mw_done_stall", 32'(bus.ctrl_stall), 32'h00);
    tick();
    chk("mw_perf", bus.perf_stall_cnt, exp_perf(15));

    // deferred flush across mem wait
    drive(0, 0, 0, 4'd0, 1, 1, 0);
    chk("df_flush0", 32'(bus.ctrl_flush), 32'd0);
    chk("df_stall0", 32'(bus.ctrl_stall), 32'h1F);
    tick();
    drive(0, 0, 0, 4'd0, 0, 1, 0);
    chk("df_flush1", 32'(bus.ctrl_flush), 32'd0);
    tick();
    drive(0, 0, 0, 4'd0, 0, 1, 1);
    chk("df_flush_ack", 32'(bus.ctrl_flush), 32'd1);
    chk("df_stall_ack", 32'(bus.ctrl_stall), 32'h00);
    tick();
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    chk("df_once", 32'(bus.ctrl_flush), 32'd0);
    chk("df_perf_f", bus.perf_flush_cnt, exp_perf(1));

    // flush over load-use
    drive(0, 1, 0, 4'd0, 1, 0, 0);
    chk("fl_lu_flush", 32'(bus.ctrl_flush), 32'd1);
    chk("fl_lu_stall", 32'(bus.ctrl_stall), 32'h00);
    tick();
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    chk("fl_lu_after", 32'(bus.ctrl_flush), 32'd0);

    // flush deferred by multi-cycle, merging with a new branch on release
    drive(0, 0, 1, 4'd2, 1, 0, 0);
    chk("fm_stall0", 32'(bus.ctrl_stall), 32'h0F);
    chk("fm_flush0", 32'(bus.ctrl_flush), 32'd0);
    tick();
    drive(0, 0, 1, 4'd2, 0, 0, 0);
    chk("fm_flush1", 32'(bus.ctrl_flush), 32'd0);
    tick();
    drive(0, 0, 0, 4'd0, 1, 0, 0);
    chk("fm_flush2", 32'(bus.ctrl_flush), 32'd1);
    chk("fm_done", 32'(bus.ctrl_mc_done), 32'd1);
    tick();
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    chk("fm_single", 32'(bus.ctrl_flush), 32'd0);
    chk("fm_perf_f", bus.perf_flush_cnt, exp_perf(3));
    chk("fm_perf_s", bus.perf_stall_cnt, exp_perf(19));

    // len=0: immediate done, no stall
    drive(0, 0, 1, 4'd0, 0, 0, 0);
    chk("l0_stall", 32'(bus.ctrl_stall), 32'h00);
    chk("l0_done", 32'(bus.ctrl_mc_done), 32'd1);
    tick();
    chk("l0_state", 32'(bus.dbg_state), 32'd0);

    // len=1: one stall cycle then done
    drive(0, 0, 1, 4'd1, 0, 0, 0);
    chk("l1_stall", 32'(bus.ctrl_stall), 32'h0F);
    tick();
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    chk("l1_done", 32'(bus.ctrl_mc_done), 32'd1);
    chk("l1_state", 32'(bus.dbg_state), 32'd2);
    tick();

    // ack without request is ignored
    drive(0, 0, 0, 4'd0, 0, 0, 1);
    chk("ack_only", 32'(bus.ctrl_stall), 32'h00);
    tick();

    // async reset in the middle of a BUSY op
    drive(0, 0, 1, 4'd6, 0, 0, 0);
    tick();
    tick();
    chk("ar_busy", 32'(bus.dbg_state), 32'd1);
    chk("ar_stall", 32'(bus.ctrl_stall), 32'h0F);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_stall0", 32'(bus.ctrl_stall), 32'h00);
    chk("ar_state", 32'(bus.dbg_state), 32'd0);
    chk("ar_perf", bus.perf_stall_cnt, 32'd0);
    drive(0, 0, 0, 4'd0, 0, 0, 0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ar_nodone%0d", k), 32'(bus.ctrl_mc_done), 32'd0);
      chk($sformatf("ar_nostall%0d", k), 32'(bus.ctrl_stall), 32'h00);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer. Collects stall and flush requests from IF, ID, EX and MEM and drives the shared ctrl_stall bus that every stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) obeys.
- Owns the EX multi-cycle operation counter, the MEM data-memory wait handshake and the deferred branch-flush latch.
- Sits beside the datapath; its only consumers are the stage registers and the EX unit.

Parameters:
STALL_W, 6, width of ctrl_stall (bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved)
MC_LEN_W, 4, width of the multi-cycle length field
PERF_W, 32, width of the performance counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
if_stall_req  input  1  instruction fetch not ready
id_stall_req  input  1  load-use hazard detected in ID
ex_mc_start  input  1  multi-cycle op present in EX (level; held while op is in EX)
ex_mc_len  input  MC_LEN_W  op length in stall cycles (0 = no stall)
ex_branch_flush  input  1  taken branch/jump resolved in EX
mem_req  input  1  MEM stage accessing data memory (mre|mwe)
mem_ack  input  1  data memory completes access this cycle
ctrl_stall  output  STALL_W  stall vector to stage registers
ctrl_flush  output  1  squash IF/ID and ID/EX this cycle
ctrl_mc_done  output  1  EX result valid; EX/MEM captures this cycle
perf_stall_cnt  output  PERF_W  cycles with any ctrl_stall bit set
perf_flush_cnt  output  PERF_W  flush pulses issued

Behaviour:
- Stall-bus contract: stall[i]=1 means register i holds. Register i inserts a bubble when stall[i]=1 and stall[i+1]=0. Bit5 is always 0.
- ctrl_stall is combinational from requests and state. Highest-priority active source wins:
  - mem_wait = mem_req & ~mem_ack -> 6'b011111
  - mc_stall (FSM in BUSY, or IDLE with ex_mc_start and ex_mc_len≠0) -> 6'b001111
  - id_stall_req -> 6'b000111
  - if_stall_req -> 6'b000011
  - none -> 0
- Multi-cycle FSM: states IDLE, BUSY, DONE; counter cnt is MC_LEN_W bits.
  - IDLE, ex_mc_start=1, len=N≥1: stall this cycle. If N=1 go to DONE; else go to BUSY with cnt=N-1.
  - IDLE, ex_mc_start=1, len=0: no stall, remain IDLE, ctrl_mc_done=1 combinationally.
  - BUSY: stall. If mem_wait, cnt and state freeze. Otherwise cnt decrements; when cnt reaches 1, go to DONE.
  - DONE: ctrl_mc_done=1, no mc stall, ex_mc_start ignored, go to IDLE. If mem_wait, hold DONE and keep ctrl_mc_done=1.
  - Total mc stall cycles equal N (excluding frozen cycles). ctrl_mc_done is asserted in the first unstalled cycle after them.
- Flush:
  - ctrl_flush=1 when (ex_branch_flush | flush_pend) & ~mem_wait & ~mc_stall.
  - If a flush request arrives while mem_wait or mc_stall is active, flush_pend is set. It clears on the cycle ctrl_flush is issued.
  - While ctrl_flush=1, ctrl_stall bits [2:0] are forced to 0, so the squash overrides load-use and fetch stalls.
  - A new ex_branch_flush coinciding with flush_pend merges into a single pulse.
- Reset (asynchronous, rst=0): FSM=IDLE, cnt=0, flush_pend=0, perf counters=0. Combinational outputs are forced low: ctrl_stall=0, ctrl_flush=0, ctrl_mc_done=0. Reset mid-op aborts the op with no done pulse.
- mem_ack without mem_req is ignored.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: perf_stall_cnt increments on every cycle with ctrl_stall≠0. perf_flush_cnt increments on every cycle with ctrl_flush=1. Both wrap modulo 2^PERF_W; reset to 0.
- Not defined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Load-use: id_stall_req=1 for 1 cycle -> ctrl_stall=6'b000111 that cycle, 0 next. If PIPE_PERF_CNT_EN, perf_stall_cnt=1.
- Multi-cycle: ex_mc_start=1, len=4, held -> ctrl_stall=6'b001111 for exactly 4 cycles, then ctrl_mc_done=1 for 1 cycle with stall=0, then FSM IDLE.
- MEM wait over mc: in BUSY with cnt=2, mem_req=1, mem_ack=0 for 3 cycles -> ctrl_stall=6'b011111 for 3 cycles, cnt frozen at 2. After ack, 2 more mc stall cycles, then done.
- Deferred flush: ex_branch_flush=1 during mem_wait -> ctrl_flush=0. On the first cycle mem_ack=1, ctrl_flush=1 exactly once.
- Flush over load-use: ex_branch_flush=1 and id_stall_req=1 together -> ctrl_flush=1, ctrl_stall=0.
- Async reset: assert rst=0 mid-BUSY (between clock edges) -> ctrl_stall=0 immediately. After release, no ctrl_mc_done pulse.
